// File: rtl/display_pkg.sv
// Shared display constants and types for the framebuffer write path.
package display_pkg;

    localparam int DISP_X_W     = 7;
    localparam int DISP_Y_W     = 6;
    localparam int DISP_COLOR_W = 24;
    localparam int DISP_ADDR_W  = 13;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef logic [DISP_ADDR_W-1:0] disp_addr_t;

    typedef enum logic {
        FILL_IDLE = 1'b0,
        FILL_RUN  = 1'b1
    } fill_state_t;

endpackage

// File: rtl/display_rect_scan.sv
// Raster row/column counter pair over a normalised rectangle; flags the last pixel.
module display_rect_scan #(
    parameter int X_W = 7,
    parameter int Y_W = 6
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           load,
    input  logic           step,
    input  logic [X_W-1:0] xl,
    input  logic [X_W-1:0] xh,
    input  logic [Y_W-1:0] yl,
    input  logic [Y_W-1:0] yh,
    output logic [X_W-1:0] col,
    output logic [Y_W-1:0] row,
    output logic           last
);

    logic [X_W-1:0] xl_q, xh_q;
    logic [Y_W-1:0] yh_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xl_q <= '0;
            xh_q <= '0;
            yh_q <= '0;
            col  <= '0;
            row  <= '0;
        end else if (load) begin
            xl_q <= xl;
            xh_q <= xh;
            yh_q <= yh;
            col  <= xl;
            row  <= yl;
        end else if (step) begin
            // step is never issued on the last pixel, so row cannot pass yh
            if (col == xh_q) begin
                col <= xl_q;
                row <= row + Y_W'(1);
            end else begin
                col <= col + X_W'(1);
            end
        end
    end

    assign last = (col == xh_q) && (row == yh_q);

endmodule

// File: rtl/display_rect_fill.sv
// Rectangle fill engine: one command in, one framebuffer write per cycle out.
module display_rect_fill
    import display_pkg::*;
#(
    parameter int X_W     = DISP_X_W,
    parameter int Y_W     = DISP_Y_W,
    parameter int COLOR_W = DISP_COLOR_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [X_W-1:0]     cmd_x0,
    input  logic [Y_W-1:0]     cmd_y0,
    input  logic [X_W-1:0]     cmd_x1,
    input  logic [Y_W-1:0]     cmd_y1,
    input  logic [COLOR_W-1:0] cmd_color,
    output logic               busy,
    output logic               done,
    output logic [X_W+Y_W-1:0] mem_waddr,
    output logic [COLOR_W-1:0] mem_wdata,
    output logic               mem_web
);

    fill_state_t    state;
    logic [X_W-1:0] xl, xh, col;
    logic [Y_W-1:0] yl, yh, row;
    logic           accept, step, last;

    assign xl = (cmd_x0 < cmd_x1) ? cmd_x0 : cmd_x1;
    assign xh = (cmd_x0 < cmd_x1) ? cmd_x1 : cmd_x0;
    assign yl = (cmd_y0 < cmd_y1) ? cmd_y0 : cmd_y1;
    assign yh = (cmd_y0 < cmd_y1) ? cmd_y1 : cmd_y0;

    assign accept = cmd_valid && cmd_ready;
    assign step   = (state == FILL_RUN) && !last;

    display_rect_scan #(.X_W(X_W), .Y_W(Y_W)) u_scan (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept),
        .step  (step),
        .xl    (xl),
        .xh    (xh),
        .yl    (yl),
        .yh    (yh),
        .col   (col),
        .row   (row),
        .last  (last)
    );

    // The scan counters are registers, so the address bus is registered too
    // and naturally holds its final value once the fill ends.
    assign mem_waddr = {row, col};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL_IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_web   <= 1'b0;
            mem_wdata <= '0;
        end else begin
            case (state)
                FILL_IDLE: begin
                    done <= 1'b0;
                    if (accept) begin
                        state     <= FILL_RUN;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        mem_web   <= 1'b1;
                        mem_wdata <= cmd_color;
                    end
                end
                FILL_RUN: begin
                    if (last) begin
                        state     <= FILL_IDLE;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        mem_web   <= 1'b0;
                    end
                end
                default: state <= FILL_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_display_rect_fill.sv
// Directed bench for display_rect_fill: reset, shapes, back-to-back, abort, random scoreboard.
module tb_display_rect_fill;
    import display_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [6:0]  cmd_x0, cmd_x1;
    logic [5:0]  cmd_y0, cmd_y1;
    logic [23:0] cmd_color;
    logic        busy, done, mem_web;
    logic [12:0] mem_waddr;
    logic [23:0] mem_wdata;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    display_rect_fill dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_x0    (cmd_x0),
        .cmd_y0    (cmd_y0),
        .cmd_x1    (cmd_x1),
        .cmd_y1    (cmd_y1),
        .cmd_color (cmd_color),
        .busy      (busy),
        .done      (done),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .mem_web   (mem_web)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents a command at a negedge; it is accepted on the following posedge.
    task automatic send(input int x0, input int y0, input int x1, input int y1,
                        input logic [23:0] color);
        @(negedge clk);
        chk("accept_ready", {31'd0, cmd_ready}, 32'd1);
        cmd_x0 = 7'(x0); cmd_y0 = 6'(y0);
        cmd_x1 = 7'(x1); cmd_y1 = 6'(y1);
        cmd_color = color;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    initial begin
        logic [12:0] exp2 [8];
        logic [12:0] exp5 [4];
        logic [12:0] first_a, last_a;
        int cnt, dk, bad, nrdy;

        exp2 = '{13'h002, 13'h003, 13'h004, 13'h005, 13'h082, 13'h083, 13'h084, 13'h085};
        exp5 = '{13'h000, 13'h001, 13'h080, 13'h081};

        rst_n = 1'b0; cmd_valid = 1'b0;
        cmd_x0 = '0; cmd_y0 = '0; cmd_x1 = '0; cmd_y1 = '0; cmd_color = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_busy",  {31'd0, busy},      32'd0);
        chk("rst_done",  {31'd0, done},      32'd0);
        chk("rst_web",   {31'd0, mem_web},   32'd0);
        chk("rst_waddr", {19'd0, mem_waddr}, 32'd0);
        chk("rst_wdata", {8'd0, mem_wdata},  32'd0);
        rst_n = 1'b1;

        // single pixel
        send(3, 2, 3, 2, 24'hFF0000);
        @(negedge clk);
        chk("px_web",   {31'd0, mem_web},   32'd1);
        chk("px_addr",  {19'd0, mem_waddr}, 32'h103);
        chk("px_data",  {8'd0, mem_wdata},  32'hFF0000);
        chk("px_busy",  {31'd0, busy},      32'd1);
        chk("px_rdy",   {31'd0, cmd_ready}, 32'd0);
        @(negedge clk);
        chk("px_web_off", {31'd0, mem_web},   32'd0);
        chk("px_done",    {31'd0, done},      32'd1);
        chk("px_busy_lo", {31'd0, busy},      32'd0);
        chk("px_rdy_hi",  {31'd0, cmd_ready}, 32'd1);
        @(negedge clk);
        chk("px_done_1cyc", {31'd0, done}, 32'd0);

        // swapped corners, two rows of four
        send(5, 1, 2, 0, 24'h00FF00);
        nrdy = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("box_web%0d", i),  {31'd0, mem_web},   32'd1);
            chk($sformatf("box_addr%0d", i), {19'd0, mem_waddr}, {19'd0, exp2[i]});
            if (!cmd_ready) nrdy++;
        end
        chk("box_data", {8'd0, mem_wdata}, 32'h00FF00);
        chk("box_rdy_lo_cycles", nrdy, 8);
        @(negedge clk);
        chk("box_done", {31'd0, done},    32'd1);
        chk("box_web",  {31'd0, mem_web}, 32'd0);

        // full screen
        send(0, 0, 127, 63, 24'h000000);
        cnt = 0; dk = 0; bad = 0; first_a = '1; last_a = '0;
        for (int k = 1; k <= 9000; k++) begin
            @(negedge clk);
            if (mem_web) begin
                if (cnt == 0) first_a = mem_waddr;
                last_a = mem_waddr;
                if (mem_wdata !== 24'h0) bad++;
                cnt++;
            end
            if (done) begin dk = k; break; end
        end
        chk("full_count",   cnt, 8192);
        chk("full_done_at", dk,  8193);
        chk("full_first",   {19'd0, first_a}, 32'h0000);
        chk("full_last",    {19'd0, last_a},  32'h1FFF);
        chk("full_data",    bad, 0);

        // back-to-back with cmd_valid held through the fill
        @(negedge clk);
        cmd_x0 = 7'd10; cmd_y0 = 6'd5; cmd_x1 = 7'd11; cmd_y1 = 6'd5; cmd_color = 24'h123456;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_x0 = 7'd20; cmd_y0 = 6'd3; cmd_x1 = 7'd20; cmd_y1 = 6'd3; cmd_color = 24'hABCDEF;
        @(negedge clk);
        chk("b2b_a0_addr", {19'd0, mem_waddr}, 32'h28A);
        chk("b2b_a0_data", {8'd0, mem_wdata},  32'h123456);
        chk("b2b_a0_rdy",  {31'd0, cmd_ready}, 32'd0);
        @(negedge clk);
        chk("b2b_a1_addr", {19'd0, mem_waddr}, 32'h28B);
        chk("b2b_a1_data", {8'd0, mem_wdata},  32'h123456);
        @(negedge clk);
        chk("b2b_a_done", {31'd0, done},      32'd1);
        chk("b2b_gap_web", {31'd0, mem_web},  32'd0);
        chk("b2b_a_rdy",  {31'd0, cmd_ready}, 32'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        chk("b2b_b_web",  {31'd0, mem_web},   32'd1);
        chk("b2b_b_addr", {19'd0, mem_waddr}, 32'h194);
        chk("b2b_b_data", {8'd0, mem_wdata},  32'hABCDEF);
        @(negedge clk);
        chk("b2b_b_done", {31'd0, done}, 32'd1);

        // reset mid-fill
        send(0, 0, 127, 63, 24'h777777);
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (mem_web) cnt++;
        end
        chk("abort_pre_writes", cnt, 10);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_web",  {31'd0, mem_web},   32'd0);
        chk("abort_busy", {31'd0, busy},      32'd0);
        chk("abort_rdy",  {31'd0, cmd_ready}, 32'd1);
        cnt = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done || mem_web) cnt++;
        end
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done || mem_web || busy) cnt++;
        end
        chk("abort_no_activity", cnt, 0);
        send(0, 0, 1, 1, 24'h0000FF);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("post_web%0d", i),  {31'd0, mem_web},   32'd1);
            chk($sformatf("post_addr%0d", i), {19'd0, mem_waddr}, {19'd0, exp5[i]});
        end
        @(negedge clk);
        chk("post_done", {31'd0, done}, 32'd1);

        // random small rectangles against a raster scoreboard
        for (int n = 0; n < 200; n++) begin
            int x0, x1, y0, y1, xl, xh, yl, yh, er, ec, area, errs;
            logic [23:0] col;
            x0 = $urandom_range(127, 0);
            y0 = $urandom_range(63, 0);
            x1 = $urandom_range((x0 < 120) ? x0 + 7 : 127, (x0 > 7) ? x0 - 7 : 0);
            y1 = $urandom_range((y0 < 56) ? y0 + 7 : 63, (y0 > 7) ? y0 - 7 : 0);
            col = 24'($urandom);
            xl = (x0 < x1) ? x0 : x1; xh = (x0 < x1) ? x1 : x0;
            yl = (y0 < y1) ? y0 : y1; yh = (y0 < y1) ? y1 : y0;
            area = (xh - xl + 1) * (yh - yl + 1);
            send(x0, y0, x1, y1, col);
            cnt = 0; errs = 0; dk = 0; er = yl; ec = xl;
            for (int k = 1; k <= area + 4; k++) begin
                @(negedge clk);
                if (mem_web) begin
                    if (int'(mem_waddr[12:7]) < yl || int'(mem_waddr[12:7]) > yh) errs++;
                    if (int'(mem_waddr[6:0]) < xl || int'(mem_waddr[6:0]) > xh) errs++;
                    if (int'(mem_waddr) != ((er << 7) | ec)) errs++;
                    if (mem_wdata !== col) errs++;
                    if (ec == xh) begin ec = xl; er++; end
                    else ec++;
                    cnt++;
                end
                if (done) begin dk = k; break; end
            end
            chk($sformatf("rnd%0d_count", n), cnt, area);
            chk($sformatf("rnd%0d_errs", n), errs, 0);
            chk($sformatf("rnd%0d_done_at", n), dk, area + 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
